// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the AES-128 inverse cipher:
//   NR          - number of AES-128 rounds (only 10 is supported)
//   BLOCK_W     - AES block width in bits
//   fsm_state_t - control FSM states (IDLE, ROUND, FINAL)
//   xtime/gf_mul - GF(2^8) arithmetic, reduction polynomial 0x11b
package aes_pkg;

    localparam int NR      = 10;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } fsm_state_t;

    // Multiply by x in GF(2^8); a carry out of bit 7 folds back as 0x1b.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; the constant operand keeps this shallow.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox
// Byte-wide FIPS-197 inverse S-box, pure lookup.
// Ports:
//   i_byte  in  8  input byte
//   o_byte  out 8  InvSubBytes(i_byte)
module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/aes128_inv_cipher.sv
// aes128_inv_cipher
// Iterative AES-128 decryption, one round per clock. Round keys come from an
// external combinational key store addressed by key_round.
// Ports:
//   clk         in  1    rising-edge clock
//   rst         in  1    asynchronous active-high reset
//   start       in  1    decrypt request, sampled only in IDLE
//   ciphertext  in  128  input block, sampled with start
//   key_round   out 4    index of the round key needed this cycle (10..0)
//   round_key   in  128  round key for key_round, same cycle
//   plaintext   out 128  result, held until the next result is produced
//   busy        out 1    high while a decryption is in progress
//   done        out 1    one-cycle pulse when plaintext becomes valid
// Timing: start accepted at edge E0, rounds on E1..E9, final round on E10.
module aes128_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BLOCK_W-1:0]   ciphertext,
    output logic [3:0]           key_round,
    input  logic [BLOCK_W-1:0]   round_key,
    output logic [BLOCK_W-1:0]   plaintext,
    output logic                 busy,
    output logic                 done
);

    localparam logic [3:0] LAST_KEY = 4'(NR);

    fsm_state_t         r_fsm;
    logic [3:0]         r_cnt;
    logic [BLOCK_W-1:0] r_state;
    logic [BLOCK_W-1:0] r_plaintext;
    logic               r_busy;
    logic               r_done;

    logic [BLOCK_W-1:0] w_isr;
    logic [BLOCK_W-1:0] w_isb;
    logic [BLOCK_W-1:0] w_ark;
    logic [BLOCK_W-1:0] w_imc;

    // Byte (r,c) lives at [127-8*(4c+r) -: 8]; row r rotates right by r.
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
    // The FINAL round takes the result before InvMixColumns (w_ark).
    assign w_isr = inv_shift_rows(r_state);

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .i_byte (w_isr[8*g +: 8]),
            .o_byte (w_isb[8*g +: 8])
        );
    end

    assign w_ark = w_isb ^ round_key;
    assign w_imc = inv_mix_columns(w_ark);

    // Key index is a pure decode of registered state so the external store
    // can answer within the same cycle.
    always_comb begin
        key_round = LAST_KEY;
        case (r_fsm)
            IDLE:    key_round = LAST_KEY;
            ROUND:   key_round = r_cnt;
            FINAL:   key_round = 4'd0;
            default: key_round = LAST_KEY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_cnt       <= 4'd0;
            r_state     <= '0;
            r_plaintext <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ciphertext ^ round_key;
                        r_cnt   <= LAST_KEY - 4'd1;
                        r_busy  <= 1'b1;
                        r_fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    r_state <= w_imc;
                    r_cnt   <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_fsm <= FINAL;
                end
                FINAL: begin
                    r_plaintext <= w_ark;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_cnt       <= 4'd0;
                    r_fsm       <= IDLE;
                end
                default: begin
                    r_fsm  <= IDLE;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign plaintext = r_plaintext;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
